// File: rtl/lsu_bus_master.sv
// lsu_bus_master: CPU load/store initiator driving a word-aligned valid/ready bus with byte strobes.
// Define LSU_MISALIGN_SPLIT_EN to run word-crossing accesses as two bus beats (otherwise they error).

module lsu_bus_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_unit,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ1 = 3'd1,
        S_RD1  = 3'd2,
`ifdef LSU_MISALIGN_SPLIT_EN
        S_REQ2 = 3'd3,
        S_RD2  = 3'd4,
`endif
        S_RESP = 3'd5
    } state_t;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

    // Pick the addressed bytes out of the (up to) two-word window and extend them.
    function automatic logic [31:0] load_extend(input logic [63:0] pair, input logic [1:0] off,
                                                input logic [2:0] unit);
        logic [31:0] d;
        d = 32'(pair >> {off, 3'b000});
        case (unit)
            3'b000:  load_extend = {{24{d[7]}}, d[7:0]};
            3'b001:  load_extend = {{16{d[15]}}, d[15:0]};
            3'b100:  load_extend = {24'h000000, d[7:0]};
            3'b101:  load_extend = {16'h0000, d[15:0]};
            default: load_extend = d;
        endcase
    endfunction

    state_t      state_r, state_nxt_s;
    logic        we_r, err_r;
    logic [2:0]  unit_r;
    logic [1:0]  off_r;
    logic [31:0] waddr_r, wdata_r, rdata_r;
    logic [3:0]  strb1_r;
    logic [15:0] cnt_r;
    logic [7:0]  acc_lanes_s;
    logic        acc_split_s, acc_illegal_s, acc_err_s, tmo_s;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic [3:0]  strb2_r;
    logic        split_r;
    logic [31:0] beat1_r;
`endif

    // Decode the incoming request: lane map, word crossing and legality.
    always_comb begin
        acc_lanes_s = 8'({4'b0000, size_mask(req_unit[1:0])} << req_addr[1:0]);
        acc_split_s = |acc_lanes_s[7:4];
        case (req_unit)
            3'b000, 3'b001, 3'b010: acc_illegal_s = 1'b0;
            3'b100, 3'b101:         acc_illegal_s = req_we;
            default:                acc_illegal_s = 1'b1;
        endcase
`ifdef LSU_MISALIGN_SPLIT_EN
        acc_err_s = acc_illegal_s;
`else
        acc_err_s = acc_illegal_s | acc_split_s;
`endif
        tmo_s = (cnt_r == TMO_LAST);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a completing handshake takes priority over timeout.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (req_valid) state_nxt_s = acc_err_s ? S_RESP : S_REQ1;
                else           state_nxt_s = S_IDLE;
            end
            S_REQ1: begin
                if (bus_ready) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    if (!we_r)        state_nxt_s = S_RD1;
                    else if (split_r) state_nxt_s = S_REQ2;
                    else              state_nxt_s = S_RESP;
`else
                    state_nxt_s = we_r ? S_RESP : S_RD1;
`endif
                end else if (tmo_s) begin
                    state_nxt_s = S_RESP;
                end else begin
                    state_nxt_s = S_REQ1;
                end
            end
            S_RD1: begin
                if (bus_rvalid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    state_nxt_s = split_r ? S_REQ2 : S_RESP;
`else
                    state_nxt_s = S_RESP;
`endif
                end else if (tmo_s) begin
                    state_nxt_s = S_RESP;
                end else begin
                    state_nxt_s = S_RD1;
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            S_REQ2: begin
                if (bus_ready)  state_nxt_s = we_r ? S_RESP : S_RD2;
                else if (tmo_s) state_nxt_s = S_RESP;
                else            state_nxt_s = S_REQ2;
            end
            S_RD2: begin
                if (bus_rvalid || tmo_s) state_nxt_s = S_RESP;
                else                     state_nxt_s = S_RD2;
            end
`endif
            S_RESP:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Request latch, wait counter, read-beat capture and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r    <= 1'b0;
            err_r   <= 1'b0;
            unit_r  <= 3'b000;
            off_r   <= 2'b00;
            waddr_r <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
            rdata_r <= 32'h0000_0000;
            strb1_r <= 4'b0000;
            cnt_r   <= 16'h0000;
`ifdef LSU_MISALIGN_SPLIT_EN
            strb2_r <= 4'b0000;
            split_r <= 1'b0;
            beat1_r <= 32'h0000_0000;
`endif
        end else begin
            if (state_nxt_s != state_r) cnt_r <= 16'h0000;
            else                        cnt_r <= cnt_r + 16'd1;
            case (state_r)
                S_IDLE: begin
                    if (req_valid) begin
                        we_r    <= req_we;
                        unit_r  <= req_unit;
                        off_r   <= req_addr[1:0];
                        waddr_r <= {req_addr[31:2], 2'b00};
                        wdata_r <= req_wdata;
                        strb1_r <= acc_lanes_s[3:0];
                        err_r   <= acc_err_s;
                        rdata_r <= 32'h0000_0000;
`ifdef LSU_MISALIGN_SPLIT_EN
                        strb2_r <= acc_lanes_s[7:4];
                        split_r <= acc_split_s;
`endif
                    end
                end
                S_REQ1: begin
                    if (!bus_ready && tmo_s) err_r <= 1'b1;
                end
                S_RD1: begin
                    if (bus_rvalid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                        beat1_r <= bus_rdata;
                        if (!split_r) rdata_r <= load_extend({32'h0000_0000, bus_rdata}, off_r, unit_r);
`else
                        rdata_r <= load_extend({32'h0000_0000, bus_rdata}, off_r, unit_r);
`endif
                    end else if (tmo_s) begin
                        err_r <= 1'b1;
                    end
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                S_REQ2: begin
                    if (!bus_ready && tmo_s) err_r <= 1'b1;
                end
                S_RD2: begin
                    if (bus_rvalid) rdata_r <= load_extend({bus_rdata, beat1_r}, off_r, unit_r);
                    else if (tmo_s) err_r <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    // Moore outputs decoded from the state and latched request.
    always_comb begin
        req_ready  = 1'b0;
        bus_valid  = 1'b0;
        bus_we     = 1'b0;
        bus_addr   = 32'h0000_0000;
        bus_wstrb  = 4'b0000;
        bus_wdata  = 32'h0000_0000;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'h0000_0000;
        case (state_r)
            S_IDLE: req_ready = 1'b1;
            S_REQ1: begin
                bus_valid = 1'b1;
                bus_we    = we_r;
                bus_addr  = waddr_r;
                if (we_r) begin
                    bus_wstrb = strb1_r;
                    bus_wdata = wdata_r << {off_r, 3'b000};
                end else begin
                    bus_wstrb = 4'b0000;
                    bus_wdata = 32'h0000_0000;
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            S_REQ2: begin
                bus_valid = 1'b1;
                bus_we    = we_r;
                bus_addr  = waddr_r + 32'd4;
                if (we_r) begin
                    bus_wstrb = strb2_r;
                    bus_wdata = wdata_r >> (6'd32 - {1'b0, off_r, 3'b000});
                end else begin
                    bus_wstrb = 4'b0000;
                    bus_wdata = 32'h0000_0000;
                end
            end
`endif
            S_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_r;
                resp_rdata = err_r ? 32'h0000_0000 : rdata_r;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed self-checking bench for lsu_bus_master with a byte-strobed memory responder.
// Follows LSU_MISALIGN_SPLIT_EN the same way as the design build.

module tb_lsu_bus_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_unit = 3'b000;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        bus_valid, bus_we;
    logic        bus_ready = 1'b1;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    int err_cnt = 0, chk_cnt = 0;
    logic [31:0] mem [logic [31:0]];
    logic        rd_en = 1'b1, inject_rv = 1'b0, pend_rd = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          beat_total = 0, start_beats = 0;
    logic [31:0] log_addr [8];
    logic [3:0]  log_strb [8];
    logic [31:0] log_data [8];
    logic [31:0] got_rdata;
    logic        got_err;
    int          got_lat, got_beats, resp_seen;

    lsu_bus_master #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_unit(req_unit),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        else return 32'h0;
    endfunction

    // Memory responder: logs beats, applies strobed writes, returns read data one cycle later.
    always @(negedge clk) begin
        bus_rvalid = pend_rd | inject_rv;
        bus_rdata  = pend_rd ? rd_word(pend_addr) : 32'h0;
        pend_rd    = 1'b0;
        if (bus_valid && bus_ready) begin
            log_addr[beat_total % 8] = bus_addr;
            log_strb[beat_total % 8] = bus_wstrb;
            log_data[beat_total % 8] = bus_wdata;
            beat_total++;
            if (bus_we) begin
                logic [31:0] w;
                w = rd_word(bus_addr);
                for (int b = 0; b < 4; b++)
                    if (bus_wstrb[b]) w[8*b +: 8] = bus_wdata[8*b +: 8];
                mem[bus_addr] = w;
            end else begin
                pend_rd   = rd_en;
                pend_addr = bus_addr;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One access: accept in cycle 0, latency counted in cycles to the resp_valid pulse.
    task automatic run_access(input logic we, input logic [2:0] unit, input logic [31:0] addr,
                              input logic [31:0] wdata);
        bit done;
        @(negedge clk);
        start_beats = beat_total;
        req_we = we; req_unit = unit; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        done = 1'b0; got_lat = 0; got_err = 1'b0; got_rdata = 32'h0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                got_rdata = resp_rdata; got_err = resp_err; got_lat = k; done = 1'b1;
            end
        end
        if (!done) check_eq("resp_wait", 32'd0, 32'd1);
        got_beats = beat_total - start_beats;
    endtask

    function automatic int bi(input int n);
        return (start_beats + n) % 8;
    endfunction

    initial begin
        #12;
        check_eq("rst_req_ready", {31'h0, req_ready}, 32'd1);
        check_eq("rst_bus_valid", {31'h0, bus_valid}, 32'd0);
        check_eq("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
        check_eq("rst_wstrb", {28'h0, bus_wstrb}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        run_access(1'b1, 3'b010, 32'h10, 32'h11223344);
        check_eq("sw_beats", got_beats, 32'd1);
        check_eq("sw_addr", log_addr[bi(0)], 32'h10);
        check_eq("sw_strb", {28'h0, log_strb[bi(0)]}, 32'hF);
        check_eq("sw_data", log_data[bi(0)], 32'h11223344);
        check_eq("sw_lat", got_lat, 32'd2);
        check_eq("sw_err", {31'h0, got_err}, 32'd0);

        mem[32'h10] = 32'h80FFFFFF;
        run_access(1'b0, 3'b000, 32'h13, 32'h0);
        check_eq("lb_strb", {28'h0, log_strb[bi(0)]}, 32'h0);
        check_eq("lb_addr", log_addr[bi(0)], 32'h10);
        check_eq("lb_data", got_rdata, 32'hFFFFFF80);
        check_eq("lb_lat", got_lat, 32'd3);
        run_access(1'b0, 3'b100, 32'h13, 32'h0);
        check_eq("lbu_data", got_rdata, 32'h00000080);
        run_access(1'b0, 3'b101, 32'h11, 32'h0);
        check_eq("lhu_off1", got_rdata, 32'h0000FFFF);

        run_access(1'b1, 3'b001, 32'h06, 32'h0000BEEF);
        check_eq("sh_addr", log_addr[bi(0)], 32'h04);
        check_eq("sh_strb", {28'h0, log_strb[bi(0)]}, 32'hC);
        check_eq("sh_data", log_data[bi(0)], 32'hBEEF0000);
        run_access(1'b0, 3'b101, 32'h06, 32'h0);
        check_eq("lhu_data", got_rdata, 32'h0000BEEF);
        run_access(1'b0, 3'b001, 32'h06, 32'h0);
        check_eq("lh_data", got_rdata, 32'hFFFFBEEF);

        mem[32'h0C] = 32'hDDCCBBAA;
        mem[32'h10] = 32'h44332211;
        run_access(1'b0, 3'b010, 32'h0E, 32'h0);
`ifdef LSU_MISALIGN_SPLIT_EN
        check_eq("lw_split_beats", got_beats, 32'd2);
        check_eq("lw_split_a1", log_addr[bi(0)], 32'h0C);
        check_eq("lw_split_a2", log_addr[bi(1)], 32'h10);
        check_eq("lw_split_data", got_rdata, 32'h2211DDCC);
        check_eq("lw_split_lat", got_lat, 32'd5);
        check_eq("lw_split_err", {31'h0, got_err}, 32'd0);
`else
        check_eq("lw_split_beats", got_beats, 32'd0);
        check_eq("lw_split_err", {31'h0, got_err}, 32'd1);
        check_eq("lw_split_data", got_rdata, 32'h0);
        check_eq("lw_split_lat", got_lat, 32'd1);
`endif

        run_access(1'b1, 3'b010, 32'hFFFFFFFF, 32'hAABBCCDD);
`ifdef LSU_MISALIGN_SPLIT_EN
        check_eq("sw_wrap_beats", got_beats, 32'd2);
        check_eq("sw_wrap_a1", log_addr[bi(0)], 32'hFFFFFFFC);
        check_eq("sw_wrap_s1", {28'h0, log_strb[bi(0)]}, 32'h8);
        check_eq("sw_wrap_d1", log_data[bi(0)], 32'hDD000000);
        check_eq("sw_wrap_a2", log_addr[bi(1)], 32'h00000000);
        check_eq("sw_wrap_s2", {28'h0, log_strb[bi(1)]}, 32'h7);
        check_eq("sw_wrap_d2", log_data[bi(1)], 32'h00AABBCC);
        check_eq("sw_wrap_lat", got_lat, 32'd3);
`else
        check_eq("sw_wrap_beats", got_beats, 32'd0);
        check_eq("sw_wrap_err", {31'h0, got_err}, 32'd1);
`endif

        run_access(1'b0, 3'b011, 32'h10, 32'h0);
        check_eq("ill_ld_err", {31'h0, got_err}, 32'd1);
        check_eq("ill_ld_beats", got_beats, 32'd0);
        check_eq("ill_ld_lat", got_lat, 32'd1);
        run_access(1'b1, 3'b100, 32'h10, 32'h55);
        check_eq("ill_st_err", {31'h0, got_err}, 32'd1);
        check_eq("ill_st_beats", got_beats, 32'd0);

        bus_ready = 1'b0;
        run_access(1'b1, 3'b010, 32'h20, 32'h12345678);
        check_eq("tmo_req_err", {31'h0, got_err}, 32'd1);
        check_eq("tmo_req_lat", got_lat, 32'd9);
        check_eq("tmo_req_beats", got_beats, 32'd0);
        @(negedge clk);
        check_eq("tmo_bus_valid", {31'h0, bus_valid}, 32'd0);
        bus_ready = 1'b1;
        rd_en = 1'b0;
        run_access(1'b0, 3'b010, 32'h20, 32'h0);
        check_eq("tmo_rd_err", {31'h0, got_err}, 32'd1);
        check_eq("tmo_rd_lat", got_lat, 32'd10);
        check_eq("tmo_rd_data", got_rdata, 32'h0);

        // Reset while waiting for read data; the access must vanish without a response.
        @(negedge clk);
        req_we = 1'b0; req_unit = 3'b010; req_addr = 32'h20; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rd1_req_ready", {31'h0, req_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_ready", {31'h0, req_ready}, 32'd1);
        check_eq("rst_mid_valid", {31'h0, bus_valid}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 inject_rv = 1'b1;
        @(negedge clk);
        #1 inject_rv = 1'b0;
        resp_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (resp_valid) resp_seen++;
        end
        check_eq("rst_no_resp", resp_seen, 32'd0);
        rd_en = 1'b1;
        mem[32'h20] = 32'hCAFEF00D;
        run_access(1'b0, 3'b010, 32'h20, 32'h0);
        check_eq("post_rst_lw", got_rdata, 32'hCAFEF00D);
        check_eq("post_rst_err", {31'h0, got_err}, 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
